// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial BCD subtractor:
//   state_t  - controller states (IDLE, RUN, DONE)
//   DIGIT_W  - width of one packed BCD digit
//   BCD_MAX  - largest legal BCD digit value
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam int DIGIT_W = 4;
   localparam int BCD_MAX = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Combinational single-digit BCD subtractor: d_o = (a_i - b_i - bin) mod 10,
// with bo set when the raw difference went negative.
// Ports:
//   a_i  [DIGIT_W-1:0] in  - minuend digit
//   b_i  [DIGIT_W-1:0] in  - subtrahend digit
//   bin                in  - borrow from the less significant digit
//   d_o  [DIGIT_W-1:0] out - result digit
//   bo                 out - borrow to the more significant digit
// -----------------------------------------------------------------------------
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_i,
   input  logic [DIGIT_W-1:0] b_i,
   input  logic               bin,
   output logic [DIGIT_W-1:0] d_o,
   output logic               bo
);

   // Two guard bits: range of a_i - b_i - bin is -16..15 for 4-bit digits.
   localparam int TW = DIGIT_W + 2;

   logic signed [TW-1:0] t;

   // Adding ten modulo 2^DIGIT_W only needs the low bits of the raw difference.
   function automatic logic [DIGIT_W-1:0] wrap_digit(input logic [DIGIT_W-1:0] lo,
                                                     input logic               neg);
      return neg ? lo + DIGIT_W'(BCD_MAX + 1) : lo;
   endfunction

   always_comb begin
      t   = $signed({2'b00, a_i}) - $signed({2'b00, b_i}) - $signed({{(TW-1){1'b0}}, bin});
      bo  = (t < 0);
      d_o = wrap_digit(t[DIGIT_W-1:0], bo);
   end

endmodule

// File: rtl/bcd_serial_sub.sv
// -----------------------------------------------------------------------------
// bcd_serial_sub
// Digit-serial packed-BCD subtractor: diff = a - b, one digit per clock,
// least significant digit first. A negative result is returned in ten's
// complement with bout=1.
// Optional feature: define BCD_SUB_DIGIT_CHECK_EN to flag operands holding a
// digit above 9 (err=1, diff and bout forced to 0). Without it err is tied 0.
// Ports:
//   clk              in  - clock, rising edge
//   rst              in  - asynchronous active-high reset
//   start            in  - begin a subtraction (only sampled while ready)
//   a    [4*NDIG-1:0] in  - minuend, digit 0 in bits [3:0]
//   b    [4*NDIG-1:0] in  - subtrahend, same packing
//   ready            out - idle, start will be accepted
//   busy             out - digits being processed
//   done             out - one-cycle pulse, result valid
//   diff [4*NDIG-1:0] out - packed BCD difference (held until next accept)
//   bout             out - final borrow, 1 when a < b
//   err              out - invalid-digit flag
// -----------------------------------------------------------------------------
module bcd_serial_sub
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIGIT_W*NDIG-1:0] a,
   input  logic [DIGIT_W*NDIG-1:0] b,
   output logic                    ready,
   output logic                    busy,
   output logic                    done,
   output logic [DIGIT_W*NDIG-1:0] diff,
   output logic                    bout,
   output logic                    err
);

   localparam int W     = DIGIT_W * NDIG;
   localparam int IDX_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx;
   logic               borrow;
   logic [W-1:0]       a_reg, b_reg;
   logic [DIGIT_W-1:0] a_dig, b_dig, d_dig;
   logic               bo_dig;
   logic               accept;
   logic               last;

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (idx == LAST_IDX) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = ready & start;
   assign last   = busy & (idx == LAST_IDX);

   // ------------------------------------------------------- operand capture
   // Operands are pure data: loaded on accept only, so later input changes
   // cannot disturb an operation in flight.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= a;
         b_reg <= b;
      end
   end

   // ------------------------------------------------------- digit datapath
   assign a_dig = a_reg[DIGIT_W*idx +: DIGIT_W];
   assign b_dig = b_reg[DIGIT_W*idx +: DIGIT_W];

   bcd_digit_sub u_digit (
      .a_i (a_dig),
      .b_i (b_dig),
      .bin (borrow),
      .d_o (d_dig),
      .bo  (bo_dig)
   );

`ifdef BCD_SUB_DIGIT_CHECK_EN
   logic err_q;
   logic bad_operand;

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (v[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX)) bad = 1'b1;
      end
      return bad;
   endfunction

   assign bad_operand = has_bad_digit(a_reg) | has_bad_digit(b_reg);
   assign err         = err_q;
`else
   assign err = 1'b0;
`endif

   // ------------------------------------------------------ result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         borrow <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
         err_q  <= 1'b0;
`endif
      end else if (accept) begin
         idx    <= '0;
         borrow <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
         err_q  <= 1'b0;
`endif
      end else if (busy) begin
         diff[DIGIT_W*idx +: DIGIT_W] <= d_dig;
         borrow                       <= bo_dig;
         if (last) begin
            // idx stays on the last digit so the selects never leave range.
            bout <= bo_dig;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            // Later assignments override the digit write above.
            if (bad_operand) begin
               diff  <= '0;
               bout  <= 1'b0;
               err_q <= 1'b1;
            end
`endif
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_sub
// Directed self-checking bench for bcd_serial_sub with NDIG=4.
// Inputs are driven at the falling edge, outputs sampled 1ns after the rising
// edge. The accept edge is the rising edge at which start is seen in IDLE;
// DONE is entered NDIG edges later (NDIG+1 cycles counting the start cycle),
// and with start held high accepts repeat every NDIG+2 edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_serial_sub;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         ready, busy, done, bout, err;
   logic [W-1:0] diff;

   int tests;
   int fails;

   bcd_serial_sub #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands with a one-cycle start pulse; returns 1ns after the
   // accept edge.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Edges after the accept edge until done is seen; -1 on timeout.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cyc = i;
            return;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({ready, busy, done, bout, err} !== 5'b10000) begin
         fails++;
         $display("FAIL reset_flags: got rdy/bsy/dn/bo/er=%b required 10000", {ready, busy, done, bout, err});
      end
      tests++;
      if (diff !== 16'h0000) begin
         fails++;
         $display("FAIL reset_diff: got %h required 0000", diff);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int cyc;
      start_op(16'h0957, 16'h0123);
      tests++;
      if ({ready, busy} !== 2'b01) begin
         fails++;
         $display("FAIL basic_busy: got ready/busy=%b required 01", {ready, busy});
      end
      wait_done(cyc);
      tests++;
      if (cyc !== NDIG) begin
         fails++;
         $display("FAIL basic_latency: got %0d edges required %0d", cyc, NDIG);
      end
      tests++;
      if (diff !== 16'h0834 || bout !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: got diff=%h bout=%b err=%b required 0834/0/0", diff, bout, err);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_pulse: got done=%b ready=%b busy=%b required 0/1/0", done, ready, busy);
      end
      @(posedge clk);
      #1;
      tests++;
      if (diff !== 16'h0834) begin
         fails++;
         $display("FAIL basic_hold: got %h required 0834", diff);
      end
   endtask

   task automatic test_ripple;
      int cyc;
      start_op(16'h1000, 16'h0001);
      wait_done(cyc);
      tests++;
      if (cyc !== NDIG || diff !== 16'h0999 || bout !== 1'b0) begin
         fails++;
         $display("FAIL ripple: got cyc=%0d diff=%h bout=%b required 4/0999/0", cyc, diff, bout);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_negative;
      int cyc;
      start_op(16'h0042, 16'h0057);
      wait_done(cyc);
      tests++;
      if (diff !== 16'h9985 || bout !== 1'b1) begin
         fails++;
         $display("FAIL neg_0042_0057: got diff=%h bout=%b required 9985/1", diff, bout);
      end
      @(posedge clk);
      #1;
      start_op(16'h0000, 16'h9999);
      wait_done(cyc);
      tests++;
      if (diff !== 16'h0001 || bout !== 1'b1) begin
         fails++;
         $display("FAIL neg_0000_9999: got diff=%h bout=%b required 0001/1", diff, bout);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero;
      int cyc;
      // Previous result 0001/bout=1 must be cleared by the accept edge.
      start_op(16'h0000, 16'h0000);
      tests++;
      if (diff !== 16'h0000 || bout !== 1'b0) begin
         fails++;
         $display("FAIL accept_clear: got diff=%h bout=%b required 0000/0", diff, bout);
      end
      wait_done(cyc);
      tests++;
      if (diff !== 16'h0000 || bout !== 1'b0) begin
         fails++;
         $display("FAIL zero: got diff=%h bout=%b required 0000/0", diff, bout);
      end
      @(posedge clk);
      #1;
      start_op(16'h9999, 16'h0000);
      wait_done(cyc);
      tests++;
      if (diff !== 16'h9999 || bout !== 1'b0) begin
         fails++;
         $display("FAIL max: got diff=%h bout=%b required 9999/0", diff, bout);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      int npulse;
      npulse = 0;
      @(negedge clk);
      a     = 16'h0957;
      b     = 16'h0123;
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int e = 1; e <= 18; e++) begin
         @(posedge clk);
         #1;
         if (done) npulse++;
         if (e == 1) begin a = 16'h9999; b = 16'h9999; end
         if (e == 7) begin a = 16'h0500; b = 16'h0200; end
         if (e == 13) start = 1'b0;
         if (e == 4) begin
            tests++;
            if (done !== 1'b1 || diff !== 16'h0834) begin
               fails++;
               $display("FAIL b2b_first: got done=%b diff=%h required 1/0834", done, diff);
            end
         end
         if (e == 5) begin
            tests++;
            if (ready !== 1'b1) begin
               fails++;
               $display("FAIL b2b_idle: got ready=%b required 1", ready);
            end
         end
         if (e == 6) begin
            tests++;
            if (ready !== 1'b0 || busy !== 1'b1) begin
               fails++;
               $display("FAIL b2b_reaccept: got ready=%b busy=%b required 0/1", ready, busy);
            end
         end
         if (e == 10) begin
            tests++;
            if (done !== 1'b1 || diff !== 16'h0000) begin
               fails++;
               $display("FAIL b2b_second: got done=%b diff=%h required 1/0000", done, diff);
            end
         end
         if (e == 16) begin
            tests++;
            if (done !== 1'b1 || diff !== 16'h0300) begin
               fails++;
               $display("FAIL b2b_third: got done=%b diff=%h required 1/0300", done, diff);
            end
         end
      end
      tests++;
      if (npulse !== 3) begin
         fails++;
         $display("FAIL b2b_pulses: got %0d required 3", npulse);
      end
   endtask

   task automatic test_reset_abort;
      int cyc;
      int npulse;
      start_op(16'h0957, 16'h0123);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      // Now processing digit 2.
      rst = 1'b1;
      #1;
      tests++;
      if ({ready, busy, done, bout, err} !== 5'b10000 || diff !== 16'h0000) begin
         fails++;
         $display("FAIL abort_reset: got rdy/bsy/dn/bo/er=%b diff=%h required 10000/0000",
                  {ready, busy, done, bout, err}, diff);
      end
      @(negedge clk);
      rst    = 1'b0;
      npulse = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) npulse++;
      end
      tests++;
      if (npulse !== 0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL abort_no_done: got pulses=%0d ready=%b required 0/1", npulse, ready);
      end
      start_op(16'h0042, 16'h0057);
      wait_done(cyc);
      tests++;
      if (cyc !== NDIG || diff !== 16'h9985 || bout !== 1'b1) begin
         fails++;
         $display("FAIL abort_recover: got cyc=%0d diff=%h bout=%b required 4/9985/1", cyc, diff, bout);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_digit_check;
      int cyc;
      start_op(16'h00A3, 16'h0001);
      wait_done(cyc);
`ifdef BCD_SUB_DIGIT_CHECK_EN
      tests++;
      if (err !== 1'b1 || diff !== 16'h0000 || bout !== 1'b0) begin
         fails++;
         $display("FAIL check_bad: got err=%b diff=%h bout=%b required 1/0000/0", err, diff, bout);
      end
`else
      tests++;
      if (err !== 1'b0 || cyc !== NDIG) begin
         fails++;
         $display("FAIL check_off: got err=%b cyc=%0d required 0/4", err, cyc);
      end
`endif
      @(posedge clk);
      #1;
      start_op(16'h0957, 16'h0123);
      tests++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL check_clear: got err=%b required 0", err);
      end
      wait_done(cyc);
      tests++;
      if (err !== 1'b0 || diff !== 16'h0834) begin
         fails++;
         $display("FAIL check_good: got err=%b diff=%h required 0/0834", err, diff);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      test_reset();
      test_basic();
      test_ripple();
      test_negative();
      test_zero();
      test_back_to_back();
      test_reset_abort();
      test_digit_check();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
